// File: rtl/piece_spawner_pkg.sv
// piece_spawner_pkg: piece type constants and spawner state encoding
package piece_spawner_pkg;
  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;
  localparam logic [2:0] PIECE_T = 3'd2;
  localparam logic [2:0] PIECE_S = 3'd3;
  localparam logic [2:0] PIECE_Z = 3'd4;
  localparam logic [2:0] PIECE_J = 3'd5;
  localparam logic [2:0] PIECE_L = 3'd6;
  localparam int NUM_PIECES = 7;
  typedef enum logic [1:0] {IDLE, LOAD, PROBE, READY} state_t;
endpackage

// File: rtl/piece_spawner_bag_probe.sv
// bag_probe: tests one candidate against the bag and yields the wrapped next candidate
module bag_probe
  import piece_spawner_pkg::*;
(
  input  logic [2:0] c_i,
  input  logic [6:0] bag_i,
  output logic       hit_o,
  output logic [2:0] next_c_o
);
  // a candidate hits when its type is still unused in the current bag
  always_comb begin
    hit_o = ~bag_i[c_i];
    next_c_o = (c_i == PIECE_L) ? PIECE_I : c_i + 3'd1;
  end
endmodule

// File: rtl/piece_spawner.sv
// piece_spawner: 7-bag piece randomizer with current piece, one-deep preview and handshake
module piece_spawner
  import piece_spawner_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        rand_in,
  input  logic               start,
  input  logic               req,
  output logic               piece_valid,
  output logic [2:0]         piece_type,
  output logic [1:0]         piece_rot,
  output logic [2:0]         next_type,
  output logic               busy,
  output logic [COUNT_W-1:0] piece_count
);
  state_t state_q, state_d;
  logic [2:0] c_q, c_d, type_q, type_d, next_q, next_d;
  logic [1:0] r_q, r_d, rot_q, rot_d;
  logic [6:0] bag_q, bag_d;
  logic fill_q, fill_d, promo_q, promo_d, valid_q, valid_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic hit;
  logic [2:0] nc, c_load;
  logic unused;
  assign unused = ^rand_in[15:5];
  assign c_load = (rand_in[2:0] == 3'd7) ? PIECE_I : rand_in[2:0];
  bag_probe u_probe (.c_i(c_q), .bag_i(bag_q), .hit_o(hit), .next_c_o(nc));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: start preempts everything, a pick is LOAD then PROBE until a hit
  always_comb begin
    state_d = start ? LOAD :
              (state_q == LOAD) ? PROBE :
              (state_q == PROBE && hit) ? (fill_q ? LOAD : READY) :
              (state_q == READY && req) ? LOAD : state_q;
  end
  // outputs decoded from state
  always_comb begin
    busy = (state_q == LOAD) || (state_q == PROBE);
  end
  // datapath next values; promo marks a refill pick whose r becomes the promoted piece's rotation
  always_comb begin
    c_d = c_q;
    r_d = r_q;
    rot_d = rot_q;
    type_d = type_q;
    next_d = next_q;
    bag_d = bag_q;
    fill_d = fill_q;
    promo_d = promo_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    if (start) begin
      bag_d = '0;
      cnt_d = '0;
      valid_d = 1'b0;
      fill_d = 1'b1;
      promo_d = 1'b0;
    end else if (state_q == LOAD) begin
      c_d = c_load;
      r_d = rand_in[4:3];
      rot_d = promo_q ? rand_in[4:3] : rot_q;
      promo_d = 1'b0;
      bag_d = (&bag_q) ? '0 : bag_q;
    end else if (state_q == PROBE) begin
      c_d = hit ? c_q : nc;
      bag_d = hit ? bag_q | (7'd1 << c_q) : bag_q;
      type_d = (hit && fill_q) ? c_q : type_q;
      rot_d = (hit && fill_q) ? r_q : rot_q;
      next_d = (hit && !fill_q) ? c_q : next_q;
      valid_d = hit && !fill_q;
      fill_d = fill_q && !hit;
    end else if (state_q == READY && req) begin
      type_d = next_q;
      valid_d = 1'b0;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      promo_d = 1'b1;
    end
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c_q <= '0;
      r_q <= '0;
      rot_q <= '0;
      type_q <= '0;
      next_q <= '0;
      bag_q <= '0;
      fill_q <= 1'b0;
      promo_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      rot_q <= rot_d;
      type_q <= type_d;
      next_q <= next_d;
      bag_q <= bag_d;
      fill_q <= fill_d;
      promo_q <= promo_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  assign piece_valid = valid_q;
  assign piece_type = type_q;
  assign piece_rot = rot_q;
  assign next_type = next_q;
  assign piece_count = cnt_q;
endmodule

// File: tb/tb_piece_spawner.sv
// tb_piece_spawner: directed checks of pick timing, bag fairness, abort and handshake
module tb_piece_spawner;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, req = 1'b0;
  logic [15:0] rand_in = '0;
  logic piece_valid, busy;
  logic [2:0] piece_type, next_type;
  logic [1:0] piece_rot;
  logic [15:0] piece_count;
  int checks = 0, passes = 0;
  logic [6:0] mask;
  logic [2:0] exp_type;
  piece_spawner #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .start(start), .req(req),
    .piece_valid(piece_valid), .piece_type(piece_type), .piece_rot(piece_rot),
    .next_type(next_type), .busy(busy), .piece_count(piece_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic s, input logic r);
    start = s;
    req = r;
    step();
    start = 1'b0;
    req = 1'b0;
  endtask
  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!piece_valid && n < max) begin
      step();
      n++;
    end
    check(tag, piece_valid, 1);
  endtask
  initial begin
    step(2);
    rst = 1'b0;
    check("rst_valid", piece_valid, 0);
    check("rst_type", piece_type, 0);
    check("rst_rot", piece_rot, 0);
    check("rst_next", next_type, 0);
    check("rst_busy", busy, 0);
    check("rst_count", piece_count, 0);
    step(5);
    check("idle_valid", piece_valid, 0);
    rand_in = 16'h0003;
    drive(1, 0);
    check("start_busy", busy, 1);
    check("start_valid", piece_valid, 0);
    step(2);
    check("fill_type", piece_type, 3);
    check("fill_rot", piece_rot, 0);
    step(2);
    check("fill_valid_e4", piece_valid, 0);
    step();
    check("fill_valid_e5", piece_valid, 1);
    check("fill_next", next_type, 4);
    check("fill_busy", busy, 0);
    drive(0, 1);
    check("req_type", piece_type, 4);
    check("req_valid", piece_valid, 0);
    check("req_count", piece_count, 1);
    step(3);
    check("req_valid_e3", piece_valid, 0);
    step();
    check("req_valid_e4", piece_valid, 1);
    check("req_next", next_type, 5);
    drive(0, 1);
    step();
    drive(0, 1);
    check("probe_req_count", piece_count, 2);
    check("probe_req_type", piece_type, 5);
    check("probe_req_valid", piece_valid, 0);
    step(3);
    check("probe_req_commit", piece_valid, 1);
    check("probe_req_next", next_type, 6);
    check("probe_req_ready", busy, 0);
    drive(0, 1);
    check("third_count", piece_count, 3);
    check("third_type", piece_type, 6);
    step(2);
    drive(1, 0);
    check("abort_count", piece_count, 0);
    check("abort_valid", piece_valid, 0);
    check("abort_busy", busy, 1);
    step(2);
    check("abort_type", piece_type, 3);
    step(3);
    check("abort_valid_e5", piece_valid, 1);
    check("abort_next", next_type, 4);
    drive(1, 1);
    check("both_count", piece_count, 0);
    check("both_valid", piece_valid, 0);
    check("both_busy", busy, 1);
    step(2);
    check("both_type", piece_type, 3);
    wait_valid("both_refill", 8);
    check("both_next", next_type, 4);
    rand_in = 16'h001F;
    drive(1, 0);
    step(2);
    check("bag_first_type", piece_type, 0);
    check("bag_first_rot", piece_rot, 3);
    step(3);
    check("bag_first_valid", piece_valid, 1);
    check("bag_first_next", next_type, 1);
    mask = 7'b0000011;
    for (int i = 0; i < 6; i++) begin
      rand_in = (i == 0) ? 16'h0008 : 16'h001F;
      exp_type = (i == 0) ? 3'd1 : 3'(i + 1);
      drive(0, 1);
      check($sformatf("bag_type_%0d", i), piece_type, exp_type);
      step();
      check($sformatf("bag_rot_%0d", i), piece_rot, (i == 0) ? 1 : 3);
      wait_valid($sformatf("bag_valid_%0d", i), 12);
      check($sformatf("bag_next_%0d", i), next_type, (i < 5) ? i + 2 : 0);
      if (i < 5) mask = mask | (7'd1 << next_type);
    end
    check("bag_permutation", mask, 7'h7F);
    check("bag_count", piece_count, 6);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
